// File: rtl/led_fx_pkg.sv
// Shared types and field layout for the LED effect driver.
// LED_FX_GAMMA_EN selects squared (gamma) PWM brightness.
package led_fx_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_CHASE   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_STATIC,
    S_BLINK,
    S_BRTH_UP,
    S_BRTH_DN,
    S_CHASE
  } state_e;

  localparam int DIM_LSB  = 16;
  localparam int DIM_MSB  = 23;
  localparam int MODE_LSB = 24;
  localparam int MODE_MSB = 25;
  localparam int RATE_LSB = 28;
  localparam int RATE_MSB = 31;

  function automatic logic [7:0] gamma8(
    input logic [7:0] level
  );
    logic [15:0] sq;
    logic [7:0]  hi;
    logic [7:0]  lo_unused;
    sq = {8'd0, level} * {8'd0, level};
    {hi, lo_unused} = sq;
    return (level == 8'hFF) ? 8'hFF : hi;
  endfunction

  function automatic state_e mode_state(
    input mode_e m
  );
    state_e s;
    unique case (m)
      MODE_BLINK:   s = S_BLINK;
      MODE_BREATHE: s = S_BRTH_UP;
      MODE_CHASE:   s = S_CHASE;
      default:      s = S_STATIC;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_fx_tickgen.sv
// Effect step prescaler: base divider of TICK_DIV cycles
// followed by a 2^rate tick counter.
module led_fx_tickgen #(
  parameter int TICK_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic [3:0] rate,
  output logic       step
);

  localparam int BW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [BW-1:0] BASE_MAX = BW'(TICK_DIV - 1);

  logic [BW-1:0] base_cnt;
  logic [14:0]   rate_cnt;
  logic [14:0]   rate_max;
  logic          base_tick;
  logic          rate_hit;

  assign rate_max  = 15'((32'd1 << rate) - 32'd1);
  assign base_tick = (base_cnt == BASE_MAX);
  assign rate_hit  = base_tick && (rate_cnt == rate_max);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_cnt <= '0;
      rate_cnt <= '0;
      step     <= 1'b0;
    end else if (clear) begin
      base_cnt <= '0;
      rate_cnt <= '0;
      step     <= 1'b0;
    end else begin
      step <= rate_hit;
      if (base_tick) begin
        base_cnt <= '0;
        rate_cnt <= rate_hit ? '0 : rate_cnt + 15'd1;
      end else begin
        base_cnt <= base_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_fx_driver.sv
// PWM-dimmed LED driver with static/blink/breathe/chase effects.
// Define LED_FX_GAMMA_EN for gamma-corrected brightness.
module led_fx_driver
  import led_fx_pkg::*;
#(
  parameter int NUM_LEDS = 10,
  parameter int TICK_DIV = 50000,
  parameter int PWM_DIV  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         ctrl_word,
  output logic [NUM_LEDS-1:0] led,
  output logic                step_tick
);

  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PW-1:0] PWM_MAX = PW'(PWM_DIV - 1);
  localparam logic [3:0] POS_MAX = 4'(NUM_LEDS - 1);
  localparam logic [31:0] USED_MASK =
    32'hF3FF_0000 | ((32'd1 << NUM_LEDS) - 32'd1);

  logic [NUM_LEDS-1:0] en_q;
  logic [7:0]          dim_q;
  mode_e               mode_q;
  logic [3:0]          rate_q;
  mode_e               mode_w;
  logic [3:0]          rate_w;
  logic                unused_bits;

  state_e      state, state_n;
  logic        phase, phase_n;
  logic [7:0]  ramp, ramp_n;
  logic [3:0]  pos, pos_n;
  logic [PW-1:0] pwm_div;
  logic [7:0]  pwm_cnt;

  logic        restart;
  logic        step;
  logic [7:0]  level;
  logic [15:0] prod;
  logic [7:0]  prod_hi;
  logic [7:0]  prod_lo_unused;
  logic [7:0]  eff_level;
  logic [7:0]  cmp_level;
  logic        pwm_lt;
  logic        pwm_on;
  logic [NUM_LEDS-1:0] led_d;

  assign mode_w      = mode_e'(ctrl_word[MODE_MSB:MODE_LSB]);
  assign rate_w      = ctrl_word[RATE_MSB:RATE_LSB];
  assign unused_bits = ^(ctrl_word & ~USED_MASK);
  assign restart     = (mode_w != mode_q) || (rate_w != rate_q);

  led_fx_tickgen #(
    .TICK_DIV(TICK_DIV)
  ) u_tickgen (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (restart),
    .rate   (rate_q),
    .step   (step)
  );

  assign step_tick = step;

  assign level = 8'hFF - dim_q;
  assign prod  = {8'd0, ramp} * {8'd0, level};
  assign {prod_hi, prod_lo_unused} = prod;

  always_comb begin
    eff_level = level;
    if (state == S_BRTH_UP || state == S_BRTH_DN) begin
      eff_level = prod_hi;
    end
`ifdef LED_FX_GAMMA_EN
    cmp_level = gamma8(eff_level);
`else
    cmp_level = eff_level;
`endif
  end

  assign pwm_lt = (pwm_cnt < cmp_level);
  assign pwm_on = (dim_q == 8'd0) | pwm_lt;

  // A restart wins over a step landing in the same cycle.
  always_comb begin
    state_n = state;
    phase_n = phase;
    ramp_n  = ramp;
    pos_n   = pos;
    if (restart) begin
      state_n = mode_state(mode_w);
      phase_n = 1'b1;
      ramp_n  = 8'd0;
      pos_n   = 4'd0;
    end else if (step) begin
      unique case (state)
        S_BLINK: phase_n = ~phase;
        S_BRTH_UP: begin
          if (ramp == 8'hFF) begin
            state_n = S_BRTH_DN;
            ramp_n  = 8'hFE;
          end else begin
            ramp_n = ramp + 8'd1;
          end
        end
        S_BRTH_DN: begin
          if (ramp == 8'h00) begin
            state_n = S_BRTH_UP;
            ramp_n  = 8'h01;
          end else begin
            ramp_n = ramp - 8'd1;
          end
        end
        S_CHASE: pos_n = (pos == POS_MAX) ? 4'd0 : pos + 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      unique case (state)
        S_STATIC:  led_d[i] = en_q[i] & pwm_on;
        S_BLINK:   led_d[i] = en_q[i] & phase & pwm_on;
        S_BRTH_UP,
        S_BRTH_DN: led_d[i] = en_q[i] & pwm_lt;
        S_CHASE:   led_d[i] = en_q[i] & (pos == 4'(i)) & pwm_on;
        default:   led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q    <= '0;
      dim_q   <= 8'd0;
      mode_q  <= MODE_STATIC;
      rate_q  <= 4'd0;
      state   <= S_STATIC;
      phase   <= 1'b1;
      ramp    <= 8'd0;
      pos     <= 4'd0;
      pwm_div <= '0;
      pwm_cnt <= 8'd0;
      led     <= '0;
    end else begin
      en_q   <= ctrl_word[NUM_LEDS-1:0];
      dim_q  <= ctrl_word[DIM_MSB:DIM_LSB];
      mode_q <= mode_w;
      rate_q <= rate_w;
      state  <= state_n;
      phase  <= phase_n;
      ramp   <= ramp_n;
      pos    <= pos_n;
      if (restart) begin
        pwm_div <= '0;
        pwm_cnt <= 8'd0;
      end else if (pwm_div == PWM_MAX) begin
        pwm_div <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        pwm_div <= pwm_div + 1'b1;
      end
      led <= led_d;
    end
  end

endmodule
